// File: rtl/dragon_head_ctrl.sv
// dragon_head_ctrl
//   Drives the dragon body segment queue. Once per frame (vsync rising edge)
//   it advances a movement counter. When the counter wraps, the head steps one
//   grid cell toward a clamped target. Pending hit/heal requests are resolved
//   into a single one-clk length-update pulse.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   vsync           frame sync; only its rising edge (in the clk domain) is used
//   target_pos      {y[3:0],x[3:0]} cell the head chases
//   hit_req         level or pulse request to shrink
//   heal_req        level or pulse request to grow
//   movementCounter frame counter 0..MOVE_PERIOD
//   Dragon_Head     [9:8] orientation (00 up, 01 right, 10 down, 11 left),
//                   [7:0] position {y,x}
//   lengthUpdate    00 none, 01 heal, 10 hit; non-zero for exactly one clk
//   dragon_len      current body length 0..MAX_LEN
module dragon_head_ctrl #(
    parameter int          MOVE_PERIOD = 10,
    parameter int          GRID_W      = 16,
    parameter int          GRID_H      = 12,
    parameter logic [7:0]  INIT_POS    = 8'h00,
    parameter int          MAX_LEN     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [7:0] target_pos,
    input  logic       hit_req,
    input  logic       heal_req,
    output logic [5:0] movementCounter,
    output logic [9:0] Dragon_Head,
    output logic [1:0] lengthUpdate,
    output logic [2:0] dragon_len
);

    localparam logic [3:0] X_MAX    = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX    = 4'(GRID_H - 1);
    localparam logic [5:0] CNT_TERM = 6'(MOVE_PERIOD);
    localparam logic [2:0] LEN_MAX  = 3'(MAX_LEN);

    localparam logic [1:0] ORI_UP    = 2'b00;
    localparam logic [1:0] ORI_RIGHT = 2'b01;
    localparam logic [1:0] ORI_DOWN  = 2'b10;
    localparam logic [1:0] ORI_LEFT  = 2'b11;

    localparam logic [1:0] LU_NONE = 2'b00;
    localparam logic [1:0] LU_HEAL = 2'b01;
    localparam logic [1:0] LU_HIT  = 2'b10;

    // Saturate a target coordinate to the last valid cell of its axis.
    function automatic logic [3:0] clamp4(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic       pre_vsync;
    logic       armed;
    logic       vs_rise;
    logic       pend_hit;
    logic       pend_heal;

    logic [3:0] x_cur, y_cur, x_t, y_t;
    logic [9:0] head_next;
    logic [1:0] lu_next;
    logic [2:0] len_next;

    // armed stays low until vsync has been seen low after reset, so a vsync
    // already high at reset release is not mistaken for a fresh edge.
    assign vs_rise = vsync & ~pre_vsync & armed;

    assign x_cur = Dragon_Head[3:0];
    assign y_cur = Dragon_Head[7:4];
    assign x_t   = clamp4(target_pos[3:0], X_MAX);
    assign y_t   = clamp4(target_pos[7:4], Y_MAX);

    // One-axis step toward the target, x has priority over y.
    always_comb begin
        head_next = Dragon_Head;
        if (x_t > x_cur)
            head_next = {ORI_RIGHT, y_cur, x_cur + 4'd1};
        else if (x_t < x_cur)
            head_next = {ORI_LEFT, y_cur, x_cur - 4'd1};
        else if (y_t > y_cur)
            head_next = {ORI_DOWN, y_cur + 4'd1, x_cur};
        else if (y_t < y_cur)
            head_next = {ORI_UP, y_cur - 4'd1, x_cur};
    end

    // Simultaneous hit and heal cancel; saturated requests are dropped.
    always_comb begin
        lu_next  = LU_NONE;
        len_next = dragon_len;
        if (pend_heal && !pend_hit && dragon_len < LEN_MAX) begin
            lu_next  = LU_HEAL;
            len_next = dragon_len + 3'd1;
        end else if (pend_hit && !pend_heal && dragon_len != 3'd0) begin
            lu_next  = LU_HIT;
            len_next = dragon_len - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_vsync       <= 1'b0;
            armed           <= 1'b0;
            pend_hit        <= 1'b0;
            pend_heal       <= 1'b0;
            movementCounter <= 6'd0;
            Dragon_Head     <= {ORI_UP, INIT_POS};
            lengthUpdate    <= LU_NONE;
            dragon_len      <= 3'd0;
        end else begin
            pre_vsync    <= vsync;
            armed        <= armed | ~vsync;
            lengthUpdate <= LU_NONE;
            if (vs_rise) begin
                // Requests arriving on this very clk belong to the next frame.
                pend_hit     <= hit_req;
                pend_heal    <= heal_req;
                lengthUpdate <= lu_next;
                dragon_len   <= len_next;
                if (movementCounter == CNT_TERM) begin
                    movementCounter <= 6'd0;
                    Dragon_Head     <= head_next;
                end else begin
                    movementCounter <= movementCounter + 6'd1;
                end
            end else begin
                pend_hit  <= pend_hit | hit_req;
                pend_heal <= pend_heal | heal_req;
            end
        end
    end

endmodule

// File: tb/tb_dragon_head_ctrl.sv
module tb_dragon_head_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic [7:0] target_pos;
    logic       hit_req;
    logic       heal_req;
    logic [5:0] movementCounter;
    logic [9:0] Dragon_Head;
    logic [1:0] lengthUpdate;
    logic [2:0] dragon_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dragon_head_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .vsync          (vsync),
        .target_pos     (target_pos),
        .hit_req        (hit_req),
        .heal_req       (heal_req),
        .movementCounter(movementCounter),
        .Dragon_Head    (Dragon_Head),
        .lengthUpdate   (lengthUpdate),
        .dragon_len     (dragon_len)
    );

    typedef struct {
        int         n;      // frames to run with these inputs
        logic [7:0] tgt;
        logic       hit;
        logic       heal;
        logic [5:0] cnt;    // expected after the last frame
        logic [9:0] head;
        logic [1:0] lu;     // expected pulse value in the clk after the last rise
        logic [2:0] len;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic [7:0] tgt, input logic hit, input logic heal,
                       input logic [5:0] cnt, input logic [9:0] head, input logic [1:0] lu,
                       input logic [2:0] len);
        vec_t v;
        v = '{n, tgt, hit, heal, cnt, head, lu, len};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame: requests for one clk, then a vsync rise; reports the pulse
    // value in the clk after the rise and in the clk after that.
    task automatic frame(input logic hit, input logic heal,
                         output logic [1:0] lu_seen, output logic [1:0] lu_after);
        @(posedge clk); #1;
        hit_req  = hit;
        heal_req = heal;
        @(posedge clk); #1;
        hit_req  = 1'b0;
        heal_req = 1'b0;
        vsync    = 1'b1;
        @(posedge clk); #1;
        lu_seen  = lengthUpdate;
        @(posedge clk); #1;
        lu_after = lengthUpdate;
        vsync    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] lu_s, lu_a;

        // Reset and target sequence
        add(10, 8'h00, 0, 0, 6'd10, 10'h000, 2'b00, 3'd0);
        add(1,  8'h00, 0, 0, 6'd0,  10'h000, 2'b00, 3'd0);
        add(10, 8'h00, 0, 0, 6'd10, 10'h000, 2'b00, 3'd0);
        add(4,  8'h00, 0, 0, 6'd3,  10'h000, 2'b00, 3'd0);
        add(8,  8'h23, 0, 0, 6'd0,  10'h101, 2'b00, 3'd0);
        add(10, 8'h23, 0, 0, 6'd10, 10'h101, 2'b00, 3'd0);
        add(1,  8'h23, 0, 0, 6'd0,  10'h102, 2'b00, 3'd0);
        add(11, 8'h23, 0, 0, 6'd0,  10'h103, 2'b00, 3'd0);
        add(11, 8'h23, 0, 0, 6'd0,  10'h213, 2'b00, 3'd0);
        add(11, 8'h23, 0, 0, 6'd0,  10'h223, 2'b00, 3'd0);
        add(11, 8'h23, 0, 0, 6'd0,  10'h223, 2'b00, 3'd0);
        add(132, 8'hFF, 0, 0, 6'd0, 10'h12F, 2'b00, 3'd0);
        add(99, 8'hFF, 0, 0, 6'd0,  10'h2BF, 2'b00, 3'd0);
        add(22, 8'hFF, 0, 0, 6'd0,  10'h2BF, 2'b00, 3'd0);
        // Heal to saturation
        for (int i = 1; i <= 7; i++)
            add(1, 8'hFF, 0, 1, 6'(i), 10'h2BF, 2'b01, 3'(i));
        add(1, 8'hFF, 0, 1, 6'd8, 10'h2BF, 2'b00, 3'd7);
        add(1, 8'hFF, 0, 1, 6'd9, 10'h2BF, 2'b00, 3'd7);
        // Shrink to 3, then cancel, then single hit
        add(1, 8'hFF, 1, 0, 6'd10, 10'h2BF, 2'b10, 3'd6);
        add(1, 8'hFF, 1, 0, 6'd0,  10'h2BF, 2'b10, 3'd5);
        add(1, 8'hFF, 1, 0, 6'd1,  10'h2BF, 2'b10, 3'd4);
        add(1, 8'hFF, 1, 0, 6'd2,  10'h2BF, 2'b10, 3'd3);
        add(1, 8'hFF, 1, 1, 6'd3,  10'h2BF, 2'b00, 3'd3);
        add(1, 8'hFF, 1, 0, 6'd4,  10'h2BF, 2'b10, 3'd2);

        reset = 1'b1; vsync = 1'b0; target_pos = 8'h00; hit_req = 1'b0; heal_req = 1'b0;
        #1;
        chk("rst_async_lu", 32'(lengthUpdate), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_cnt",  32'(movementCounter), 32'h0);
        chk("rst_head", 32'(Dragon_Head), 32'h000);
        chk("rst_lu",   32'(lengthUpdate), 32'h0);
        chk("rst_len",  32'(dragon_len), 32'h0);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            target_pos = vecs[k].tgt;
            for (int f = 0; f < vecs[k].n; f++)
                frame(vecs[k].hit, vecs[k].heal, lu_s, lu_a);
            chk($sformatf("v%0d_cnt", k),  32'(movementCounter), 32'(vecs[k].cnt));
            chk($sformatf("v%0d_head", k), 32'(Dragon_Head), 32'(vecs[k].head));
            chk($sformatf("v%0d_len", k),  32'(dragon_len), 32'(vecs[k].len));
            chk($sformatf("v%0d_lu", k),   32'(lu_s), 32'(vecs[k].lu));
            chk($sformatf("v%0d_lu_w", k), 32'(lu_a), 32'h0);
        end

        // Request in the same clk as the rise belongs to the next frame
        @(posedge clk); #1;
        heal_req = 1'b1; vsync = 1'b1;
        @(posedge clk); #1;
        heal_req = 1'b0;
        chk("same_clk_lu",  32'(lengthUpdate), 32'h0);
        chk("same_clk_cnt", 32'(movementCounter), 32'd5);
        @(posedge clk); #1;
        vsync = 1'b0;
        frame(1'b0, 1'b0, lu_s, lu_a);
        chk("deferred_lu",  32'(lu_s), 32'h1);
        chk("deferred_len", 32'(dragon_len), 32'd3);
        chk("deferred_cnt", 32'(movementCounter), 32'd6);

        // vsync held high yields one edge only
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("held_cnt", 32'(movementCounter), 32'd7);

        // Reset one clk after a rise that issued a heal pulse
        vsync = 1'b0; heal_req = 1'b1;
        @(posedge clk); #1;
        heal_req = 1'b0; vsync = 1'b1;
        @(posedge clk); #1;
        chk("mid_lu_pre",  32'(lengthUpdate), 32'h1);
        chk("mid_len_pre", 32'(dragon_len), 32'd4);
        reset = 1'b1;
        #1;
        chk("mid_lu",   32'(lengthUpdate), 32'h0);
        chk("mid_len",  32'(dragon_len), 32'h0);
        chk("mid_head", 32'(Dragon_Head), 32'h000);
        chk("mid_cnt",  32'(movementCounter), 32'h0);

        // vsync high at reset release is not an edge
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("rel_high_cnt", 32'(movementCounter), 32'h0);
        vsync = 1'b0;
        @(posedge clk); #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        chk("rel_edge_cnt", 32'(movementCounter), 32'd1);
        chk("rel_edge_lu",  32'(lengthUpdate), 32'h0);
        vsync = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
